punct_conv_encoder: RTL and testbench
=====================================

PUNCT_CONV_ENCODER -- requirements
Module: punct_conv_encoder

Interface
REQ-001 Parameter K, 7, constraint length; legal range 3..9.
REQ-002 Parameter G0, 7'o133, generator A polynomial, K bits; MSB taps the current input bit.
REQ-003 Parameter G1, 7'o171, generator B polynomial, K bits; MSB taps the current input bit.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  frame-start pulse: clears encoder state and latches rate_sel.
REQ-007 rate_sel  in  2  code rate: 00=1/2, 01=2/3, 10=3/4, 11=reserved, treated as 1/2.
REQ-008 in_valid  in  1  in_bit is valid.
REQ-009 in_bit  in  1  scrambled data bit.
REQ-010 in_ready  out  1  block accepts in_bit this cycle.
REQ-011 out_valid  out  1  out_bit is valid.
REQ-012 out_bit  out  1  coded and punctured bit, registered.
REQ-013 out_ready  in  1  downstream (interleaver write side) consumes out_bit.
REQ-014 busy  out  1  high while the holding register holds at least one bit.

Function
REQ-015 Shift register sr, K-1 bits, shall hold previous inputs; the most recent input occupies the position adjacent to the current bit.
REQ-016 On accept (in_valid && in_ready && !start), A = XOR-reduce({in_bit,sr} & G0), B = XOR-reduce({in_bit,sr} & G1); sr shifts in in_bit.
REQ-017 Puncture phase counter p shall advance on each accept, wrapping at 2 (rate 2/3) or 3 (rate 3/4); p stays 0 at rate 1/2.
REQ-018 Kept bits per phase: 1/2 -> A,B; 2/3 -> p0 A,B, p1 A; 3/4 -> p0 A,B, p1 A, p2 B.
REQ-019 Kept bits shall load a 2-entry holding register with count 1 or 2 and be emitted A before B, one per out handshake.
REQ-020 out_valid shall be high exactly when count>0; out_bit shall be the head entry; latency is one cycle from accept to out_valid.
REQ-021 in_ready = !start && (count==0 || (count==1 && out_ready)); no bit shall be lost or duplicated under back-pressure.
REQ-022 While out_valid && !out_ready, out_bit and count shall hold stable.
REQ-023 start shall have priority over everything in the same cycle: sr, p and count clear to 0, pending bits are discarded, rate is latched, in_ready is 0 that cycle.
REQ-024 The latched rate shall be unaffected by rate_sel changes between start pulses.
REQ-025 With count==1, a simultaneous out handshake and accept shall emit the old bit and load the new kept bits in the same cycle.
REQ-026 busy shall equal out_valid.

Reset
REQ-027 While reset==0 at a clk edge: sr=0, p=0, count=0, latched rate=1/2, out_valid=0, out_bit=0, busy=0; in_ready reads 1 when start==0.
REQ-028 Reset mid-frame shall discard all pending bits; the first output after reset release shall not depend on pre-reset input.

Configuration
REQ-029 Macro PCE_PUNCTURE_EN defined: rates 2/3 and 3/4 are supported per REQ-017/018.
REQ-030 Macro PCE_PUNCTURE_EN undefined: rate_sel and the phase counter are removed, and every accept keeps A,B (rate 1/2 only).

Verification
REQ-031 Rate 1/2, start, then inputs 1,0,0,0,0,0,0 with out_ready=1 -> out sequence 11 01 11 11 00 10 11.
REQ-032 Rate 3/4, inputs 1,0,0,0,0,0 -> 8 bits 1,1,0,1,1,1,0,0; p back at 0.
REQ-033 Rate 2/3, inputs 1,0,0,0 -> 6 bits 1,1,0,1,1,1.
REQ-034 Rate 1/2, out_ready low 5 cycles mid-stream -> out_bit stable, in_ready 0, full sequence matches REQ-031 with no gaps or repeats.
REQ-035 After 3 inputs, pulse start with in_valid high -> that input is not accepted, out_valid is 0 next cycle, next accepted input 1 yields 1,1.
REQ-036 Macro undefined with rate_sel=10, same stimulus as REQ-031 -> identical 14-bit output.

Source files
------------

// File: rtl/punct_conv_encoder.sv
// Rate-1/2 convolutional encoder with optional 2/3 and 3/4 puncturing and a 2-entry output holding register.
// Puncturing is compiled in only when PCE_PUNCTURE_EN is defined; otherwise every input yields A then B.
module punct_conv_encoder #(
  parameter int           K  = 7,
  parameter logic [K-1:0] G0 = 7'o133,
  parameter logic [K-1:0] G1 = 7'o171
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] rate_sel,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_bit,
  input  logic       out_ready,
  output logic       busy
);

  logic [K-2:0] sr_reg;
  logic [1:0]   count_reg;
  logic         head_reg;
  logic         tail_reg;
  logic [K-1:0] window;
  logic         bit_a;
  logic         bit_b;
  logic [1:0]   keep_n;
  logic         keep_first;
  logic         keep_second;
  logic         accept;
  logic         pop;

  // Current bit is the MSB of the window; sr MSB is the most recent past input.
  assign window = {in_bit, sr_reg};
  assign bit_a  = ^(window & G0);
  assign bit_b  = ^(window & G1);

  // A new group may only load once the register will be empty after this cycle.
  assign in_ready  = !start && (count_reg == 2'd0 || (count_reg == 2'd1 && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_bit   = head_reg;
  assign busy      = out_valid;

`ifdef PCE_PUNCTURE_EN
  logic [1:0] rate_reg;
  logic [1:0] phase_reg;
  logic [1:0] phase_last;

  always_comb begin
    phase_last  = 2'd0;
    keep_n      = 2'd2;
    keep_first  = bit_a;
    keep_second = bit_b;
    case (rate_reg)
      2'b01:   phase_last = 2'd1;
      2'b10:   phase_last = 2'd2;
      default: phase_last = 2'd0;
    endcase
    if (phase_reg == 2'd1) begin
      keep_n     = 2'd1;
      keep_first = bit_a;
    end else if (phase_reg == 2'd2) begin
      keep_n     = 2'd1;
      keep_first = bit_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rate_reg  <= 2'b00;
      phase_reg <= 2'd0;
    end else if (start) begin
      rate_reg  <= rate_sel;
      phase_reg <= 2'd0;
    end else if (accept) begin
      phase_reg <= (phase_reg == phase_last) ? 2'd0 : phase_reg + 2'd1;
    end
  end
`else
  logic unused_rate_sel;

  assign unused_rate_sel = ^rate_sel;
  assign keep_n          = 2'd2;
  assign keep_first      = bit_a;
  assign keep_second     = bit_b;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_reg    <= '0;
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
    end else if (start) begin
      sr_reg    <= '0;
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
    end else if (accept) begin
      // Any pending bit is popped this same cycle, so the new group overwrites the register.
      sr_reg    <= {in_bit, sr_reg[K-2:1]};
      count_reg <= keep_n;
      head_reg  <= keep_first;
      tail_reg  <= keep_second;
    end else if (pop) begin
      count_reg <= count_reg - 2'd1;
      head_reg  <= tail_reg;
    end
  end

endmodule

// File: tb/tb_punct_conv_encoder.sv
// Randomized and directed self-checking bench for punct_conv_encoder against a queue-based reference model.
// Puncture-rate checks run only when PCE_PUNCTURE_EN is defined.
module tb_punct_conv_encoder;

  localparam int       K   = 7;
  localparam bit [6:0] G0M = 7'o133;
  localparam bit [6:0] G1M = 7'o171;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] rate_sel;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_q[$];
  bit got_q[$];
  bit hist[$];
  int n_acc  = 0;
  int rate_m = 0;
  bit last_acc;

  punct_conv_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rate_sel (rate_sel),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Convolution computed directly from the input history, then punctured by frame position.
  task automatic push_kept(input bit b);
    bit a;
    bit bb;
    bit x;
    int per;
    int ph;
    a  = 1'b0;
    bb = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (j == 0) x = b;
      else x = (j - 1 < hist.size()) ? hist[j-1] : 1'b0;
      a  ^= G0M[K-1-j] & x;
      bb ^= G1M[K-1-j] & x;
    end
`ifdef PCE_PUNCTURE_EN
    per = (rate_m == 1) ? 2 : (rate_m == 2) ? 3 : 1;
`else
    per = 1;
`endif
    ph = n_acc % per;
    if (ph != 2) exp_q.push_back(a);
    if (ph == 0 || ph == 2) exp_q.push_back(bb);
    hist.push_front(b);
    if (hist.size() > K - 1) void'(hist.pop_back());
    n_acc++;
  endtask

  task automatic step();
    int pend;
    bit exp_ir;
    @(negedge clk);
    pend   = exp_q.size();
    exp_ir = !start && (pend == 0 || (pend == 1 && out_ready));
    check("out_valid", {31'd0, out_valid}, {31'd0, pend > 0});
    check("busy", {31'd0, busy}, {31'd0, pend > 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    if (pend > 0) check("out_bit", {31'd0, out_bit}, {31'd0, exp_q[0]});
    last_acc = 1'b0;
    if (out_valid && out_ready) got_q.push_back(out_bit);
    if (!reset) begin
      exp_q.delete(); hist.delete(); n_acc = 0; rate_m = 0;
    end else if (start) begin
      exp_q.delete(); hist.delete(); n_acc = 0; rate_m = int'(rate_sel);
    end else begin
      if (pend > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ir) begin
        push_kept(in_bit);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit b);
    int t;
    in_valid = 1'b1;
    in_bit   = b;
    t = 0;
    do begin
      step();
      t++;
    end while (!last_acc && t < 50);
    if (!last_acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic new_frame(input logic [1:0] r);
    start    = 1'b1;
    rate_sel = r;
    step();
    start = 1'b0;
    got_q.delete();
  endtask

  function automatic logic [31:0] packed_got();
    logic [31:0] v;
    v = '0;
    foreach (got_q[i]) v = {v[30:0], got_q[i]};
    return v;
  endfunction

  task automatic run_seq(input logic [1:0] r, input int n, input string tag,
                         input int exp_len, input logic [31:0] exp_bits);
    new_frame(r);
    for (int i = 0; i < n; i++) send(i == 0);
    repeat (6) step();
    check({tag, "_len"}, got_q.size(), exp_len);
    check({tag, "_seq"}, packed_got(), exp_bits);
  endtask

  initial begin
    logic ob;
    reset = 1'b0; start = 1'b0; rate_sel = 2'b00;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bit", {31'd0, out_bit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    step();

    run_seq(2'b00, 7, "r12", 14, 32'b11011111001011);

    // Back-pressure in the middle of the same stream
    new_frame(2'b00);
    send(1'b1); send(1'b0); send(1'b0);
    out_ready = 1'b0;
    ob = out_bit;
    repeat (5) begin
      step();
      check("bp_hold", {31'd0, out_bit}, {31'd0, ob});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    repeat (4) send(1'b0);
    repeat (6) step();
    check("bp_len", got_q.size(), 14);
    check("bp_seq", packed_got(), 32'b11011111001011);

    // start mid-frame with an input offered in the same cycle
    new_frame(2'b00);
    send(1'b1); send(1'b0); send(1'b1);
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("start_flush", {31'd0, out_valid}, 32'd0);
    got_q.delete();
    send(1'b1);
    repeat (4) step();
    check("start_len", got_q.size(), 2);
    check("start_seq", packed_got(), 32'b11);

`ifdef PCE_PUNCTURE_EN
    run_seq(2'b10, 6, "r34", 8, 32'b11011100);
    run_seq(2'b01, 4, "r23", 6, 32'b110111);
`else
    run_seq(2'b10, 7, "norate", 14, 32'b11011111001011);
`endif

    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 150) == 0;
      reset     = ($urandom % 400) != 0;
      rate_sel  = 2'($urandom);
      in_valid  = ($urandom % 10) < 7;
      in_bit    = 1'($urandom);
      out_ready = ($urandom % 10) < 6;
      step();
    end
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
